// File: rtl/axi_lite_spi_cmd_master.sv
// Single-outstanding command port to AXI4-Lite master bridge with registered outputs.
// Define AXI_CMD_TIMEOUT_EN to add a hung-slave wait counter that forces a 2'b11 response.
module axi_lite_spi_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [31:0] axi_lite_awaddr,
  output logic        axi_lite_awvalid,
  input  logic        axi_lite_awready,
  output logic [31:0] axi_lite_wdata,
  output logic [3:0]  axi_lite_wstrb,
  output logic        axi_lite_wvalid,
  input  logic        axi_lite_wready,
  input  logic [1:0]  axi_lite_bresp,
  input  logic        axi_lite_bvalid,
  output logic        axi_lite_bready,
  output logic [31:0] axi_lite_araddr,
  output logic        axi_lite_arvalid,
  input  logic        axi_lite_arready,
  input  logic [31:0] axi_lite_rdata,
  input  logic        axi_lite_rvalid,
  output logic        axi_lite_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t      state_reg, state_next;
  logic        aw_done_reg, aw_done_next, w_done_reg, w_done_next;
  logic [31:0] addr_reg, addr_next, wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [1:0]  resp_reg, resp_next;
  logic        cmd_ready_reg, cmd_ready_next;
  logic        awvalid_reg, awvalid_next, wvalid_reg, wvalid_next;
  logic        bready_reg, bready_next, arvalid_reg, arvalid_next;
  logic        rready_reg, rready_next, rsp_valid_reg, rsp_valid_next;
  logic        timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rdata_reg     <= '0;
      resp_reg      <= '0;
      cmd_ready_reg <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      rdata_reg     <= rdata_next;
      resp_reg      <= resp_next;
      cmd_ready_reg <= cmd_ready_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    rdata_next   = rdata_reg;
    resp_next    = resp_reg;
    case (state_reg)
      IDLE: begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (cmd_valid && cmd_ready_reg) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          wstrb_next = cmd_wstrb;
          state_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order
        aw_done_next = aw_done_reg | (awvalid_reg & axi_lite_awready);
        w_done_next  = w_done_reg | (wvalid_reg & axi_lite_wready);
        if (aw_done_next && w_done_next) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (bready_reg && axi_lite_bvalid) begin
          rdata_next = '0;
          resp_next  = axi_lite_bresp;
          state_next = RSP;
        end
      end
      RD_REQ: begin
        if (arvalid_reg && axi_lite_arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (rready_reg && axi_lite_rvalid) begin
          rdata_next = axi_lite_rdata;
          resp_next  = 2'b00;
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_valid_reg && rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A handshake landing in the expiry cycle still wins over the timeout
    if (timeout && state_next == state_reg) begin
      state_next = RSP;
      rdata_next = '0;
      resp_next  = 2'b11;
    end
  end

`ifdef AXI_CMD_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        waiting;

  assign waiting = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                   (state_reg == RD_REQ) || (state_reg == RD_DATA);
  assign timeout = waiting && (wait_cnt_reg == WAIT_LAST);

  always_comb begin
    wait_cnt_next = '0;
    if (state_next == state_reg && waiting) wait_cnt_next = wait_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wait_cnt_reg <= '0;
    else         wait_cnt_reg <= wait_cnt_next;
  end
`else
  assign timeout = 1'b0;
`endif

  // Outputs are registered versions of what the next state requires
  always_comb begin
    cmd_ready_next = (state_next == IDLE);
    awvalid_next   = (state_next == WR_REQ) && !aw_done_next;
    wvalid_next    = (state_next == WR_REQ) && !w_done_next;
    bready_next    = (state_next == WR_RESP);
    arvalid_next   = (state_next == RD_REQ);
    rready_next    = (state_next == RD_DATA);
    rsp_valid_next = (state_next == RSP);
  end

  assign cmd_ready        = cmd_ready_reg;
  assign rsp_valid        = rsp_valid_reg;
  assign rsp_rdata        = rdata_reg;
  assign rsp_resp         = resp_reg;
  assign axi_lite_awaddr  = addr_reg;
  assign axi_lite_awvalid = awvalid_reg;
  assign axi_lite_wdata   = wdata_reg;
  assign axi_lite_wstrb   = wstrb_reg;
  assign axi_lite_wvalid  = wvalid_reg;
  assign axi_lite_bready  = bready_reg;
  assign axi_lite_araddr  = addr_reg;
  assign axi_lite_arvalid = arvalid_reg;
  assign axi_lite_rready  = rready_reg;

endmodule

// File: tb/tb_axi_lite_spi_cmd_master.sv
// Directed plus randomized bench for axi_lite_spi_cmd_master; the bench plays the AXI slave
// cycle by cycle and predicts responses from a word-addressed memory model.
module tb_axi_lite_spi_cmd_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0, rready;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  axi_lite_spi_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_lite_awaddr(awaddr), .axi_lite_awvalid(awvalid), .axi_lite_awready(awready),
    .axi_lite_wdata(wdata), .axi_lite_wstrb(wstrb), .axi_lite_wvalid(wvalid),
    .axi_lite_wready(wready), .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid),
    .axi_lite_bready(bready), .axi_lite_araddr(araddr), .axi_lite_arvalid(arvalid),
    .axi_lite_arready(arready), .axi_lite_rdata(rdata), .axi_lite_rvalid(rvalid),
    .axi_lite_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
  endfunction

  task automatic check_rsp(input logic [31:0] er, input logic [1:0] ep, input int hold);
    for (int h = 0; h <= hold; h++) begin
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk32("rsp_rdata", rsp_rdata, er);
      chk2("rsp_resp", rsp_resp, ep);
      chk1("rsp_cmd_ready", cmd_ready, 1'b0);
      rsp_ready = (h == hold);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk1("rsp_drop", rsp_valid, 1'b0);
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_d, input int w_d, input int b_d,
                          input logic [1:0] br, input int hold, input bit keep);
    bit aw_hs, w_hs, b_hs;
    int last, rsp_j, exp_j;
    logic [31:0] sa, sd;
    logic [3:0] ss;
    aw_hs = 0; w_hs = 0; b_hs = 0; last = -1; rsp_j = -1;
    sa = '0; sd = '0; ss = '0;
    exp_j = ((aw_d > w_d) ? aw_d : w_d) + b_d + 2;
    chk1("wr_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = keep; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    for (int j = 0; j < 200; j++) begin
      if (rsp_valid) begin
        rsp_j = j;
        break;
      end
      chk1("wr_cmd_busy", cmd_ready, 1'b0);
      chk1("wr_awvalid", awvalid, !aw_hs);
      if (!aw_hs) chk32("wr_awaddr", awaddr, a);
      chk1("wr_wvalid", wvalid, !w_hs);
      if (!w_hs) begin
        chk32("wr_wdata", wdata, d);
        chk4("wr_wstrb", wstrb, s);
      end
      chk1("wr_bready", bready, (last >= 0) && !b_hs);
      chk1("wr_arvalid", arvalid, 1'b0);
      awready = !aw_hs && (j >= aw_d);
      wready  = !w_hs && (j >= w_d);
      if (awready) begin aw_hs = 1; sa = awaddr; end
      if (wready) begin w_hs = 1; sd = wdata; ss = wstrb; end
      if (aw_hs && w_hs && last < 0) last = j;
      bvalid = 1'b0;
      bresp = 2'($urandom);
      if (last >= 0 && !b_hs && j >= last + 1 + b_d) begin
        bvalid = 1'b1;
        bresp = br;
        b_hs = 1;
        if (br == 2'b00) slave_mem[sa] = merge(slave_read(sa), sd, ss);
      end
      @(negedge clk);
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    chk32("wr_latency", rsp_j, exp_j);
    if (br == 2'b00) model_mem[a] = merge(model_read(a), d, s);
    $display("WR addr=%h data=%h strb=%h resp=%b lat=%0d", a, d, s, br, rsp_j);
    check_rsp(32'h0, br, hold);
  endtask

  task automatic do_read(input logic [31:0] a, input int ar_d, input int r_d,
                         input int hold, input bit keep);
    bit ar_hs, r_hs;
    int last, rsp_j;
    logic [31:0] sa, exp_d;
    ar_hs = 0; r_hs = 0; last = -1; rsp_j = -1; sa = '0;
    exp_d = model_read(a);
    chk1("rd_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_wdata = $urandom;
    @(negedge clk);
    cmd_valid = keep; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    for (int j = 0; j < 200; j++) begin
      if (rsp_valid) begin
        rsp_j = j;
        break;
      end
      chk1("rd_cmd_busy", cmd_ready, 1'b0);
      chk1("rd_arvalid", arvalid, !ar_hs);
      if (!ar_hs) chk32("rd_araddr", araddr, a);
      chk1("rd_rready", rready, (last >= 0) && !r_hs);
      chk1("rd_awvalid", awvalid, 1'b0);
      chk1("rd_wvalid", wvalid, 1'b0);
      arready = !ar_hs && (j >= ar_d);
      if (arready) begin ar_hs = 1; last = j; sa = araddr; end
      rvalid = 1'b0;
      rdata = $urandom;
      if (last >= 0 && !r_hs && j >= last + 1 + r_d) begin
        rvalid = 1'b1;
        rdata = slave_read(sa);
        r_hs = 1;
      end
      @(negedge clk);
    end
    arready = 1'b0; rvalid = 1'b0;
    chk32("rd_latency", rsp_j, ar_d + r_d + 2);
    $display("RD addr=%h exp=%h got=%h lat=%0d", a, exp_d, rsp_rdata, rsp_j);
    check_rsp(exp_d, 2'b00, hold);
  endtask

  initial begin
    int n_hi;
    logic [31:0] ra, rd;
    slave_mem[32'h0] = 32'h0000_00C3;
    model_mem[32'h0] = 32'h0000_00C3;

    // Reset state
    @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk2("rst_rsp_resp", rsp_resp, 2'b00);
    chk32("rst_awaddr", awaddr, 32'h0);
    chk32("rst_araddr", araddr, 32'h0);
    chk32("rst_wdata", wdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases
    do_write(32'h4, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'b00, 0, 1'b0);
    do_write(32'h4, 32'h1234_5678, 4'b0110, 3, 0, 0, 2'b00, 1, 1'b0);
    do_read(32'h0, 0, 5, 4, 1'b0);
    do_read(32'h4, 1, 0, 0, 1'b0);
    do_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 2, 2'b10, 0, 1'b0);
    do_write(32'hC, 32'h0BAD_F00D, 4'hF, 1, 2, 1, 2'b10, 2, 1'b1);
    do_write(32'h10, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b00, 0, 1'b0);
    do_read(32'h10, 0, 0, 0, 1'b0);

    // Reset while waiting in the read data phase
    chk1("mid_pre_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk1("mid_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk1("mid_rready_before", rready, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk1("mid_rready_async", rready, 1'b0);
    chk1("mid_rsp_valid_async", rsp_valid, 1'b0);
    chk1("mid_cmd_ready_async", cmd_ready, 1'b0);
    chk32("mid_araddr_async", araddr, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk1("mid_cmd_ready_after", cmd_ready, 1'b1);
    chk1("mid_rsp_valid_after", rsp_valid, 1'b0);
    do_read(32'h14, 1, 0, 0, 1'b0);

    // Slave never accepts the address
    chk1("hang_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100;
    cmd_wdata = 32'hFEED_0001; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_hi = 0;
`ifdef AXI_CMD_TIMEOUT_EN
    for (int j = 0; j < 100; j++) begin
      if (awvalid !== 1'b1) break;
      n_hi++;
      wready = (j == 0);
      @(negedge clk);
    end
    wready = 1'b0;
    chk32("to_aw_cycles", n_hi, 32'd16);
    chk1("to_bready", bready, 1'b0);
    chk1("to_wvalid", wvalid, 1'b0);
    $display("WR addr=%h timeout after %0d cycles resp=%b", 32'h100, n_hi, rsp_resp);
    check_rsp(32'h0, 2'b11, 0);
`else
    for (int j = 0; j < 1000; j++) begin
      if (awvalid === 1'b1 && awaddr === 32'h100) n_hi++;
      wready = (j == 0);
      @(negedge clk);
    end
    wready = 1'b0;
    chk32("noto_aw_cycles", n_hi, 32'd1000);
    chk1("noto_rsp_valid", rsp_valid, 1'b0);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk1("noto_aw_drop", awvalid, 1'b0);
    chk1("noto_bready", bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    $display("WR addr=%h held %0d cycles then completed", 32'h100, n_hi);
    check_rsp(32'h0, 2'b00, 0);
`endif

    // Randomized traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      bit keep;
      keep = (i != 39) && ($urandom_range(0, 1) == 1);
      ra = 32'($urandom_range(0, 15)) << 2;
      rd = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(ra, rd, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                 $urandom_range(0, 3), keep);
      else
        do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), keep);
    end
    cmd_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_spi_cmd_master.md
# axi_lite_spi_cmd_master

Command-to-AXI4-Lite master bridge that sits directly upstream of the AXI4-Lite SPI master slave. It accepts single read/write commands on a simple valid/ready command port and turns each into exactly one AXI4-Lite transaction. When the transaction completes, it returns read data and response on a valid/ready response port. One transaction is in flight at a time; there is no pipelining between commands.

## Interface
- TIMEOUT_CYCLES, 1024: handshake wait limit in clk cycles; used only with AXI_CMD_TIMEOUT_EN.
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge idle and able to accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  AXI address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  0 = OKAY, 2'b10 = SLVERR from bresp, 2'b11 = timeout.
- axi_lite_awaddr / awvalid  out  32/1; axi_lite_awready  in  1.
- axi_lite_wdata / wstrb / wvalid  out  32/4/1; axi_lite_wready  in  1.
- axi_lite_bresp  in  2; axi_lite_bvalid  in  1; axi_lite_bready  out  1.
- axi_lite_araddr / arvalid  out  32/1; axi_lite_arready  in  1.
- axi_lite_rdata  in  32; axi_lite_rvalid  in  1; axi_lite_rready  out  1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/wdata/wstrb. Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ: awvalid and wvalid assert together. Each drops independently on its own handshake; awready and wready may arrive in either order or the same cycle. Track completion with aw_done and w_done flags. When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0, go to RSP.
- RD_REQ: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata, set rsp_resp=0 (slave has no rresp), go to RSP.
- RSP: rsp_valid=1 with stable data. On rsp_ready, go to IDLE.
- Address, data and strobes come from the latched copies and stay stable while the corresponding valid is high; cmd_* changes after acceptance have no effect.
- The bridge never asserts an AXI valid without a pending command, and never deasserts a valid before its handshake (except on timeout, see Configuration).
- Reset mid-operation: all outputs return to reset values immediately and the FSM goes to IDLE. The in-flight command is lost; no response is issued for it.

## Timing
- Reset values:
  - cmd_ready=0 while resetn is low; it is registered, so it goes to 1 on the first clk edge after resetn deasserts.
  - All AXI valid/ready outputs = 0; rsp_valid=0; rsp_rdata=0; rsp_resp=0.
  - All AXI address/data outputs = 0.
- Command accepted at edge N: AXI valids are high from cycle N+1. cmd_ready is low from N+1 until the cycle after the RSP handshake.
- bready/rready are registered and high the cycle after the last request handshake.
- Response capture at edge M: rsp_valid is high from M+1.
- Minimum write round trip with zero-wait slave (accept, AW/W, B, response): 4 cycles. Read round trip: 4 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- AXI_CMD_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on every state change and increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1, all AXI valids/readies drop and the FSM goes to RSP with rsp_resp=2'b11 and rsp_rdata=0.
  - This deliberately violates AXI handshake rules, for hung-slave recovery only.
  - The counter does not run in IDLE or RSP.
- Undefined: no counter logic; the bridge waits indefinitely in every state.

## Test plan
- Write addr 0x4, data 0xA5A5_0001, wstrb 0xF; slave asserts awready, wready and bvalid (bresp=0) immediately -> AW/W high 1 cycle, rsp_valid with rsp_resp=0, rsp_rdata=0, cmd_ready back after rsp_ready.
- Write with wready 3 cycles before awready -> wvalid drops after W handshake, awvalid held with stable 0x4 until awready, single B handshake.
- Read addr 0x0; slave returns rdata 0x0000_00C3 after 5 wait cycles -> rsp_rdata=0x0000_00C3, rsp_resp=0; rsp_valid holds while rsp_ready is low for 4 cycles.
- Write with bresp=2'b10 -> rsp_resp=2'b10; back-to-back commands with cmd_valid held high -> second command is accepted only after the first response handshake.
- resetn pulsed low while in RD_DATA -> rready and rsp_valid go 0 asynchronously; the next command after reset completes normally.
- With AXI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, awready never asserted -> valids drop at wait cycle 16, rsp_resp=2'b11; without the macro -> awvalid stays high for 1000 cycles.
